// File: rtl/seven_segment_mux.sv
// seven_segment_mux: time-multiplexed driver for an N-digit common-anode
// seven-segment display. One digit is lit at a time for REFRESH_CYCLES
// cycles. Input data, blank and dp controls are latched into shadow registers
// once per frame, so a digit never shows a torn value. All outputs are
// registered and active-low.
//
// Optional feature macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN
//   When defined, zero nibbles above the most significant nonzero digit are
//   shown dark (segments off). Digit 0 is never suppressed. Anode and dp of a
//   suppressed digit still follow blank_in and dp_in.
module seven_segment_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              segment,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic                    prime_reg;
    logic                    load_seen_reg;
    logic [4*NUM_DIGITS-1:0] data_shadow_reg;
    logic [NUM_DIGITS-1:0]   blank_shadow_reg;
    logic [NUM_DIGITS-1:0]   dp_shadow_reg;
    logic [6:0]              segment_reg;
    logic                    dp_reg;
    logic [NUM_DIGITS-1:0]   anode_reg;
    logic                    frame_start_reg;

    logic [6:0]              segment_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   anode_next;

    logic                    cnt_wrap;
    logic                    load_now;
    logic [3:0]              shadow_nib [NUM_DIGITS];

    assign cnt_wrap = (cnt_reg == CNT_LAST);
    // A load happens on the frame wrap (last digit back to digit 0) or on the
    // first edge after reset release.
    assign load_now = prime_reg || (cnt_wrap && (idx_reg == IDX_LAST));

    // Unpack the shadow nibbles so the current digit can be selected by index.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign shadow_nib[gi] = data_shadow_reg[4*gi +: 4];
        end
    endgenerate

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] supp_next;
    logic [NUM_DIGITS-1:0] supp_shadow_reg;

    // Walk from the top digit down; a digit is suppressed while every digit
    // at or above it is zero. Digit 0 always stays visible.
    always_comb begin
        logic run;
        supp_next = '0;
        run       = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run          = run && (data_in[4*k +: 4] == 4'h0);
            supp_next[k] = run;
        end
    end

    // Suppression mask is latched together with the rest of the shadow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            supp_shadow_reg <= '0;
        end else if (load_now) begin
            supp_shadow_reg <= supp_next;
        end
    end
`endif

    // Output decode for the digit currently selected by idx.
    always_comb begin
        anode_next   = '1;
        segment_next = 7'h7F;
        dp_next      = 1'b1;
        if (!blank_shadow_reg[idx_reg]) begin
            anode_next   = ~(NUM_DIGITS'(1) << idx_reg);
            segment_next = hex_to_seg(shadow_nib[idx_reg]);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
            if (supp_shadow_reg[idx_reg]) begin
                segment_next = 7'h7F;
            end
`endif
            dp_next      = ~dp_shadow_reg[idx_reg];
        end
    end

    // Refresh counter, digit index, shadow loads and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg          <= '0;
            idx_reg          <= '0;
            prime_reg        <= 1'b1;
            load_seen_reg    <= 1'b0;
            data_shadow_reg  <= '0;
            blank_shadow_reg <= '1;
            dp_shadow_reg    <= '0;
            segment_reg      <= 7'h7F;
            dp_reg           <= 1'b1;
            anode_reg        <= '1;
            frame_start_reg  <= 1'b0;
        end else begin
            if (cnt_wrap) begin
                cnt_reg <= '0;
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            prime_reg <= 1'b0;
            if (load_now) begin
                data_shadow_reg  <= data_in;
                blank_shadow_reg <= blank_in;
                dp_shadow_reg    <= dp_in;
            end

            // frame_start lines up with the first output cycle of the new
            // shadow contents, one edge after the load itself.
            load_seen_reg   <= load_now;
            frame_start_reg <= load_seen_reg;

            segment_reg <= segment_next;
            dp_reg      <= dp_next;
            anode_reg   <= anode_next;
        end
    end

    assign segment     = segment_reg;
    assign dp          = dp_reg;
    assign anode       = anode_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed testbench for seven_segment_mux with NUM_DIGITS=4, REFRESH_CYCLES=4.
// Walks reset, scan order, frame-synchronous update, blank/dp, leading zeros
// and a mid-frame reset, checking every output each cycle.
module tb_seven_segment_mux;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic [3:0]  blank_in;
    logic [3:0]  dp_in;
    logic [6:0]  segment;
    logic        dp;
    logic [3:0]  anode;
    logic        frame_start;

    int tests;
    int fails;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'h7F;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SEG_LEAD0 = 7'h7F;
`else
    localparam logic [6:0] SEG_LEAD0 = 7'b1000000;
`endif

    seven_segment_mux #(
        .NUM_DIGITS    (4),
        .REFRESH_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .blank_in   (blank_in),
        .dp_in      (dp_in),
        .segment    (segment),
        .dp         (dp),
        .anode      (anode),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dark(input string tag, input logic exp_fs);
        check({tag, "_anode"}, 32'(anode), 32'h0F);
        check({tag, "_seg"}, 32'(segment), 32'h7F);
        check({tag, "_dp"}, 32'(dp), 32'h1);
        check({tag, "_fs"}, 32'(frame_start), 32'(exp_fs));
    endtask

    // Advance 'cycles' edges, checking all outputs after each one.
    task automatic run_slot(input string tag, input int cycles, input logic [3:0] exp_an,
                            input logic [6:0] exp_seg, input logic exp_dp, input logic fs_first);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check({tag, "_anode"}, 32'(anode), 32'(exp_an));
            check({tag, "_seg"}, 32'(segment), 32'(exp_seg));
            check({tag, "_dp"}, 32'(dp), 32'(exp_dp));
            check({tag, "_fs"}, 32'(frame_start), (i == 0) ? 32'(fs_first) : 32'h0);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        data_in  = 16'h3A7F;
        blank_in = 4'b0000;
        dp_in    = 4'b0000;

        // Reset held
        tick();
        tick();
        check_dark("reset_hold", 1'b0);
        reset = 1'b0;

        // Edge 1: prime load, still dark
        tick();
        check_dark("edge1", 1'b0);

        // Scan order, first (short) frame then a full one
        run_slot("scan_d0a", 3, 4'hE, SEG_F, 1'b1, 1'b1);
        run_slot("scan_d1a", 4, 4'hD, SEG_7, 1'b1, 1'b0);
        run_slot("scan_d2a", 4, 4'hB, SEG_A, 1'b1, 1'b0);
        run_slot("scan_d3a", 4, 4'h7, SEG_3, 1'b1, 1'b0);
        run_slot("scan_d0b", 4, 4'hE, SEG_F, 1'b1, 1'b1);

        // Change data while digit 1 lit: old frame continues
        run_slot("sync_d1a", 1, 4'hD, SEG_7, 1'b1, 1'b0);
        data_in = 16'h0000;
        run_slot("sync_d1b", 3, 4'hD, SEG_7, 1'b1, 1'b0);
        run_slot("sync_d2", 4, 4'hB, SEG_A, 1'b1, 1'b0);
        run_slot("sync_d3", 4, 4'h7, SEG_3, 1'b1, 1'b0);
        run_slot("zero_d0", 4, 4'hE, SEG_0, 1'b1, 1'b1);

        // Blank and dp applied next frame
        data_in  = 16'h1234;
        blank_in = 4'b0100;
        dp_in    = 4'b0001;
        run_slot("zero_d1", 4, 4'hD, SEG_LEAD0, 1'b1, 1'b0);
        run_slot("zero_d2", 4, 4'hB, SEG_LEAD0, 1'b1, 1'b0);
        run_slot("zero_d3", 4, 4'h7, SEG_LEAD0, 1'b1, 1'b0);
        run_slot("bdp_d0", 4, 4'hE, SEG_4, 1'b0, 1'b1);

        // Leading zeros next frame
        data_in  = 16'h0050;
        blank_in = 4'b0000;
        dp_in    = 4'b0000;
        run_slot("bdp_d1", 4, 4'hD, SEG_3, 1'b1, 1'b0);
        run_slot("bdp_d2", 4, 4'hF, SEG_OFF, 1'b1, 1'b0);
        run_slot("bdp_d3", 4, 4'h7, SEG_1, 1'b1, 1'b0);
        run_slot("lz_d0", 4, 4'hE, SEG_0, 1'b1, 1'b1);
        run_slot("lz_d1", 4, 4'hD, SEG_5, 1'b1, 1'b0);
        run_slot("lz_d2", 1, 4'hB, SEG_LEAD0, 1'b1, 1'b0);

        // Mid-frame reset: immediate, no edge needed
        reset = 1'b1;
        #1;
        check_dark("midrst_async", 1'b0);
        tick();
        check_dark("midrst_hold", 1'b0);
        reset = 1'b0;
        tick();
        check_dark("midrst_edge1", 1'b0);
        run_slot("rst_d0", 3, 4'hE, SEG_0, 1'b1, 1'b1);
        run_slot("rst_d1", 4, 4'hD, SEG_5, 1'b1, 1'b0);
        run_slot("rst_d2", 4, 4'hB, SEG_LEAD0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
